uart_tx_buffered: RTL and testbench

- UART transmitter: serialises 8-bit bytes as 8N1 frames (start, 8 data LSB-first, 1 or 2 stop) on `tx`.
- Bit timing uses the shared 16x-oversampling baud-tick pulse `b_tick`, the same tick that feeds the receive path.
- A one-entry holding register accepts the next byte while the current frame is being shifted, giving back-to-back frames with no idle gap.
- Sits between the command/response logic and the board TX pin.

---
 rtl/uart_tx_buffered.sv | 157 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// ============================================================================
// Module      : uart_tx_buffered
// Description : 8N1/8N2 UART transmitter with a one-entry holding register.
//               Optional parity bit is enabled by `define UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buffered #(
    parameter int TICKS_PER_BIT = 16,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_tick,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam logic [4:0] c_tick_last = 5'(TICKS_PER_BIT - 1);
    localparam logic [2:0] c_stop_last = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    generate
        if (TICKS_PER_BIT < 2 || TICKS_PER_BIT > 31 || STOP_BITS < 1 || STOP_BITS > 2
            || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
            $error("uart_tx_buffered: illegal parameter value");
        end
    endgenerate

    state_t      r_state;
    logic [4:0]  r_tick_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_hold_data;
    logic        r_hold_valid;

    logic        w_bit_end;
    logic        w_last_stop;
    logic        w_load;

`ifdef UART_TX_PARITY_EN
    // Parity comes from a copy taken at load; r_shift is consumed as bits go out.
    logic [7:0]  r_par_byte;
    logic        w_parity;
    assign w_parity = (^r_par_byte) ^ (PARITY_ODD != 0);
`endif

    assign w_bit_end   = (r_state != S_IDLE) && b_tick && (r_tick_cnt == c_tick_last);
    assign w_last_stop = (r_state == S_STOP) && (r_bit_cnt == c_stop_last) && w_bit_end;
    assign w_load      = r_hold_valid && ((r_state == S_IDLE) || w_last_stop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= 5'd0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_hold_data  <= 8'd0;
            r_hold_valid <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_byte   <= 8'd0;
`endif
            tx           <= 1'b1;
            tx_ready     <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_done <= w_last_stop;

            // Accept needs an empty holding register, so it never collides with a load.
            if (tx_start && tx_ready) begin
                r_hold_data  <= tx_data;
                r_hold_valid <= 1'b1;
                tx_ready     <= 1'b0;
            end

            if (w_load) begin
                r_shift      <= r_hold_data;
`ifdef UART_TX_PARITY_EN
                r_par_byte   <= r_hold_data;
`endif
                r_hold_valid <= 1'b0;
                tx_ready     <= 1'b1;
                r_tick_cnt   <= 5'd0;
                r_state      <= S_START;
                tx           <= 1'b0;
                tx_busy      <= 1'b1;
            end else if (r_state != S_IDLE && b_tick) begin
                if (!w_bit_end) begin
                    r_tick_cnt <= r_tick_cnt + 5'd1;
                end else begin
                    r_tick_cnt <= 5'd0;
                    case (r_state)
                        S_START: begin
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_DATA;
                            tx        <= r_shift[0];
                        end
                        S_DATA: begin
                            r_shift <= r_shift >> 1;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= 3'd0;
`ifdef UART_TX_PARITY_EN
                                r_state   <= S_PARITY;
                                tx        <= w_parity;
`else
                                r_state   <= S_STOP;
                                tx        <= 1'b1;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                tx        <= r_shift[1];
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        S_PARITY: begin
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_STOP;
                            tx        <= 1'b1;
                        end
`endif
                        S_STOP: begin
                            if (r_bit_cnt == c_stop_last) begin
                                r_state <= S_IDLE;
                                tx_busy <= 1'b0;
                                tx      <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            tx      <= 1'b1;
                            tx_busy <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
// Module      : tb_uart_tx_buffered
// Description : Directed self-checking bench; dut_a uses 1 stop bit / even
//               parity, dut_b uses 2 stop bits / odd parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_tick = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] data_a = 8'd0, data_b = 8'd0;
    logic       ready_a, busy_a, done_a, tx_a;
    logic       ready_b, busy_b, done_b, tx_b;

    int total = 0;
    int bad   = 0;
    int ndone_a = 0;
    int ndone_b = 0;
    logic [1:0] tick_div = 2'd0;

    uart_tx_buffered #(.TICKS_PER_BIT(16), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .b_tick(b_tick), .tx_start(start_a), .tx_data(data_a),
        .tx_ready(ready_a), .tx_busy(busy_a), .tx_done(done_a), .tx(tx_a)
    );

    uart_tx_buffered #(.TICKS_PER_BIT(16), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst(rst), .b_tick(b_tick), .tx_start(start_b), .tx_data(data_b),
        .tx_ready(ready_b), .tx_busy(busy_b), .tx_done(done_b), .tx(tx_b)
    );

    always #5 clk = ~clk;

    // One b_tick every 4 clks: a bit period is 64 clks.
    always @(negedge clk) begin
        tick_div = tick_div + 2'd1;
        b_tick   = (tick_div == 2'd0);
    end

    always @(negedge clk) begin
        if (done_a === 1'b1) ndone_a++;
        if (done_b === 1'b1) ndone_b++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int s);
        return (s != 0) ? tx_b : tx_a;
    endfunction

    task automatic write_byte(input int s, input logic [7:0] d);
        @(negedge clk);
        if (s != 0) begin start_b = 1'b1; data_b = d; end
        else        begin start_a = 1'b1; data_a = d; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_fall(input int s);
        int n;
        n = 0;
        while (tx_of(s) !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("start_timeout", 32'd0, 32'd1);
    endtask

    // Samples each bit at its centre; cont=1 expects the start bit one period after the previous stop sample.
    task automatic recv(input int s, input bit cont, output logic [7:0] d, output logic p);
        int nstop;
        nstop = (s != 0) ? 2 : 1;
        d = 8'd0;
        p = 1'b0;
        if (cont) repeat (64) @(negedge clk);
        else begin
            wait_fall(s);
            repeat (32) @(negedge clk);
        end
        chk("start_bit", {31'd0, tx_of(s)}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (64) @(negedge clk);
            d[i] = tx_of(s);
        end
`ifdef UART_TX_PARITY_EN
        repeat (64) @(negedge clk);
        p = tx_of(s);
`endif
        for (int i = 0; i < nstop; i++) begin
            repeat (64) @(negedge clk);
            chk("stop_bit", {31'd0, tx_of(s)}, 32'd1);
        end
    endtask

    task automatic count_low(input int s, input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx_of(s) !== 1'b1) lows++;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       p;
        int         base;
        int         lows;

        repeat (4) @(negedge clk);
        chk("rst_tx_a", {31'd0, tx_a}, 32'd1);
        chk("rst_ready_a", {31'd0, ready_a}, 32'd1);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_done_a", {31'd0, done_a}, 32'd0);
        chk("rst_tx_b", {31'd0, tx_b}, 32'd1);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Single byte 0x55
        base = ndone_a;
        write_byte(0, 8'h55);
        recv(0, 1'b0, d, p);
        chk("data_55", {24'd0, d}, 32'h55);
        repeat (64) @(negedge clk);
        chk("done_55", ndone_a - base, 1);
        chk("idle_busy_55", {31'd0, busy_a}, 32'd0);
        chk("idle_tx_55", {31'd0, tx_a}, 32'd1);

        // Back-to-back 0xA3 then 0x3C
        base = ndone_a;
        write_byte(0, 8'hA3);
        fork
            recv(0, 1'b0, d, p);
            begin
                repeat (200) @(negedge clk);
                chk("ready_before_3c", {31'd0, ready_a}, 32'd1);
                write_byte(0, 8'h3C);
                chk("ready_after_3c", {31'd0, ready_a}, 32'd0);
            end
        join
        chk("data_a3", {24'd0, d}, 32'hA3);
        chk("ready_low_in_stop", {31'd0, ready_a}, 32'd0);
        recv(0, 1'b1, d, p);
        chk("data_3c", {24'd0, d}, 32'h3C);
        chk("ready_after_b2b", {31'd0, ready_a}, 32'd1);
        repeat (64) @(negedge clk);
        chk("done_b2b", ndone_a - base, 2);

        // Overrun: 0x33 dropped
        base = ndone_a;
        write_byte(0, 8'h11);
        fork
            recv(0, 1'b0, d, p);
            begin
                repeat (10) @(negedge clk);
                write_byte(0, 8'h22);
                repeat (10) @(negedge clk);
                chk("ready_before_33", {31'd0, ready_a}, 32'd0);
                write_byte(0, 8'h33);
            end
        join
        chk("data_11", {24'd0, d}, 32'h11);
        recv(0, 1'b1, d, p);
        chk("data_22", {24'd0, d}, 32'h22);
        count_low(0, 1500, lows);
        chk("no_third_frame", lows, 0);
        chk("done_overrun", ndone_a - base, 2);

        // Two stop bits, 0xFF
        base = ndone_b;
        write_byte(1, 8'hFF);
        recv(1, 1'b0, d, p);
        chk("data_ff", {24'd0, d}, 32'hFF);
        chk("done_not_yet_2stop", ndone_b - base, 0);
        repeat (64) @(negedge clk);
        chk("done_2stop", ndone_b - base, 1);
        chk("busy_2stop", {31'd0, busy_b}, 32'd0);

        // Byte 0x07 on both instances (parity checked when compiled in)
        write_byte(0, 8'h07);
        recv(0, 1'b0, d, p);
        chk("data_07_a", {24'd0, d}, 32'h07);
`ifdef UART_TX_PARITY_EN
        chk("parity_even_07", {31'd0, p}, 32'd1);
`endif
        write_byte(1, 8'h07);
        recv(1, 1'b0, d, p);
        chk("data_07_b", {24'd0, d}, 32'h07);
`ifdef UART_TX_PARITY_EN
        chk("parity_odd_07", {31'd0, p}, 32'd0);
`endif
        repeat (100) @(negedge clk);

        // Reset during data bit 3
        write_byte(0, 8'h5A);
        wait_fall(0);
        repeat (32 + 64 * 3) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy_a}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_tx", {31'd0, tx_a}, 32'd1);
        chk("midrst_ready", {31'd0, ready_a}, 32'd1);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        count_low(0, 1500, lows);
        chk("no_residual_frame", lows, 0);
        chk("post_rst_ready", {31'd0, ready_a}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
